fifo_rd_packer: RTL and testbench
=================================

// Module: fifo_rd_packer
// PURPOSE
//  Read-side consumer of the asynchronous FIFO, running entirely in the read clock domain.
//  Pops DATA_WIDTH words through the FIFO's r_en/empty/data_out interface (one-cycle read latency).
//  Packs PACK consecutive words into one wide word on a valid/ready output stream.
//  Supports a flush that emits a partial word with a lane-keep mask.
// PARAMETERS
//  DATA_WIDTH  8  width of one FIFO word; must match the FIFO's DATA_WIDTH
//  PACK        4  FIFO words per output word; PACK >= 2, need not be a power of two
// PORTS
//  rclock      in   1               read-domain clock; all logic is on its rising edge
//  rreset      in   1               asynchronous, active-low reset (asserted at 0), shared with the FIFO read side
//  fifo_empty  in   1               FIFO empty flag
//  fifo_dout   in   DATA_WIDTH      FIFO data_out; valid the cycle after an accepted pop
//  fifo_r_en   out  1               FIFO pop request (combinational)
//  flush       in   1               single-cycle request to emit the partial accumulator
//  out_data    out  DATA_WIDTH*PACK packed word; lane 0 = bits [DATA_WIDTH-1:0] = oldest word
//  out_keep    out  PACK            lane-valid mask; all ones for a full word
//  out_valid   out  1               output word valid
//  out_ready   in   1               downstream accepts when out_valid && out_ready
//  busy        out  1               acc_cnt != 0 || rd_pend || flush_pend || out_valid
// BEHAVIOUR
//  Reset (rreset=0): acc, acc_cnt, rd_pend, flush_pend = 0; out_data, out_keep, out_valid = 0.
//  fifo_r_en is forced to 0 while rreset=0.
//  Reset mid-operation discards in-flight and accumulated words. The FIFO is reset together, so nothing is duplicated.
//  State: acc[PACK] lanes; acc_cnt in 0..PACK with width $clog2(PACK+1); rd_pend = pop issued last cycle; flush_pend sticky.
//  xfer = (acc_cnt==PACK || (flush_pend && acc_cnt!=0 && !rd_pend)) && (!out_valid || out_ready).
//  fifo_r_en = !fifo_empty && !flush_pend && ((acc_cnt + rd_pend) < PACK || (xfer && acc_cnt==PACK)).
//  rd_pend <= fifo_r_en (the FIFO ignores r_en when empty, and fifo_r_en already excludes empty).
//  Capture when rd_pend=1: fifo_dout goes into lane acc_cnt. If xfer fires in the same cycle, it goes into lane 0 and acc_cnt <= 1.
//  On xfer:
//   out_data <= acc, with lanes >= acc_cnt zeroed.
//   out_keep <= (1<<acc_cnt)-1.
//   out_valid <= 1.
//   acc_cnt <= 0, or 1 if capturing.
//   A flush-driven xfer clears flush_pend.
//  out_valid clears on out_ready when no new xfer occurs. out_data/out_keep hold stable while out_valid && !out_ready.
//  Flush:
//   flush=1 sets flush_pend and blocks new pops. The in-flight word (rd_pend) is still captured.
//   With acc_cnt==0 and !rd_pend, flush_pend clears in 1 cycle and emits nothing.
//   flush while flush_pend=1 is a no-op.
//  Throughput: a full word is produced at most every PACK+1 cycles with fifo_empty=0 and out_ready=1.
//  First-byte latency: pop at cycle 0, capture at cycle 1. Word ready after PACK captures, out_valid one cycle later.
//  Backpressure: with out_valid && !out_ready and acc full, pops stop. No word is ever dropped or overwritten.
//  fifo_empty rising with rd_pend=1: the pending word is still captured, and no further pop is issued.
// STRUCTURE
//  Shared package fifo_pkg: DATA_WIDTH default, PACK default, typedef lane_t = logic [DATA_WIDTH-1:0].
//  Flat module. No sub-module: accumulator, output register and pop control are tightly coupled.
// TESTING
//  1. Reset with fifo_empty=0: fifo_r_en=0 during reset; first pop 1 cycle after release. Push 8'h11..8'h44 -> one beat 32'h44332211, keep 4'hF.
//  2. 12 bytes, out_ready=1: three beats. Beats start at 5-cycle intervals. No fifo_r_en pulse while fifo_empty=1.
//  3. out_ready=0 for 20 cycles with 8 bytes queued: beat 1 held stable, acc holds beat 2, pops stop. Release -> beats 1, 2 in order.
//  4. 3 bytes 8'hA1,8'hA2,8'hA3, then flush -> beat 32'h00A3A2A1, keep 4'h7. flush with acc empty -> no beat.
//  5. flush in the same cycle as a pop -> the in-flight byte is included in the partial beat, and no pop is issued after flush.
//  6. rreset asserted mid-word (acc_cnt=2, out_valid=1) -> all outputs 0 asynchronously. Clean restart afterwards.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults for the FIFO read-side packer.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PACK       = 4;

    typedef logic [DEF_DATA_WIDTH-1:0] lane_t;

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops FIFO words (1-cycle read latency) and packs PACK of them into
// one wide valid/ready beat; flush emits a partial beat with a keep mask.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PACK       = DEF_PACK
) (
    input  logic                       rclock,
    input  logic                       rreset,
    input  logic                       fifo_empty,
    input  logic [DATA_WIDTH-1:0]      fifo_dout,
    output logic                       fifo_r_en,
    input  logic                       flush,
    output logic [DATA_WIDTH*PACK-1:0] out_data,
    output logic [PACK-1:0]            out_keep,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy
);

    localparam int CW = $clog2(PACK + 1);

    logic [DATA_WIDTH-1:0]      acc [PACK];
    logic [CW-1:0]              acc_cnt;
    logic                       rd_pend;
    logic                       flush_pend;
    logic                       full;
    logic                       flush_fire;
    logic                       xfer;
    logic                       space;
    logic [DATA_WIDTH*PACK-1:0] pack_data;
    logic [PACK-1:0]            pack_keep;

    always_comb begin
        full       = (acc_cnt == CW'(PACK));
        flush_fire = flush_pend && (acc_cnt != '0) && !rd_pend;
        xfer       = (full || flush_fire) && (!out_valid || out_ready);
        space      = (int'(acc_cnt) + int'(rd_pend)) < PACK;
        fifo_r_en  = rreset && !fifo_empty && !flush_pend
                     && (space || (xfer && full));
        busy       = (acc_cnt != '0) || rd_pend || flush_pend || out_valid;
    end

    // Lanes above the fill level may hold stale words; mask them out.
    always_comb begin
        pack_data = '0;
        pack_keep = '0;
        for (int i = 0; i < PACK; i++) begin
            pack_keep[i] = (i < int'(acc_cnt));
            if (pack_keep[i]) begin
                pack_data[i*DATA_WIDTH +: DATA_WIDTH] = acc[i];
            end
        end
    end

    always_ff @(posedge rclock or negedge rreset) begin
        if (!rreset) begin
            for (int i = 0; i < PACK; i++) begin
                acc[i] <= '0;
            end
            acc_cnt <= '0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= fifo_r_en;
            if (rd_pend) begin
                if (xfer) begin
                    acc[0]  <= fifo_dout;
                    acc_cnt <= CW'(1);
                end else begin
                    for (int i = 0; i < PACK; i++) begin
                        if (i == int'(acc_cnt)) begin
                            acc[i] <= fifo_dout;
                        end
                    end
                    acc_cnt <= acc_cnt + CW'(1);
                end
            end else if (xfer) begin
                acc_cnt <= '0;
            end
        end
    end

    // An empty flush (nothing held or in flight) retires after one cycle.
    always_ff @(posedge rclock or negedge rreset) begin
        if (!rreset) begin
            flush_pend <= 1'b0;
        end else if ((xfer && flush_fire)
                     || (flush_pend && acc_cnt == '0 && !rd_pend)) begin
            flush_pend <= 1'b0;
        end else if (flush) begin
            flush_pend <= 1'b1;
        end
    end

    always_ff @(posedge rclock or negedge rreset) begin
        if (!rreset) begin
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_data  <= pack_data;
            out_keep  <= pack_keep;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: FIFO model, byte-grouping reference
// model, and a monitor that checks every accepted beat.
module tb_fifo_rd_packer;
    import fifo_pkg::*;

    localparam int W = DEF_DATA_WIDTH;
    localparam int P = DEF_PACK;

    logic           rclock = 1'b0;
    logic           rreset = 1'b0;
    logic           fifo_empty;
    logic [W-1:0]   fifo_dout;
    logic           fifo_r_en;
    logic           flush = 1'b0;
    logic [W*P-1:0] out_data;
    logic [P-1:0]   out_keep;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           busy;

    fifo_rd_packer #(.DATA_WIDTH(W), .PACK(P)) dut (
        .rclock     (rclock),
        .rreset     (rreset),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_r_en  (fifo_r_en),
        .flush      (flush),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 rclock = ~rclock;

    // Simple FIFO with one-cycle read latency
    lane_t mem [0:1023];
    int    wr_ptr = 0;
    int    rd_ptr = 0;
    logic  fifo_clr = 1'b0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge rclock or negedge rreset) begin
        if (!rreset) begin
            fifo_dout <= '0;
            if (fifo_clr) rd_ptr <= wr_ptr;
        end else if (fifo_r_en && !fifo_empty) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Reference model: bytes in push order, grouped PACK at a time
    lane_t          pend[$];
    logic [W*P-1:0] exp_d[$];
    logic [P-1:0]   exp_k[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int empty_pops = 0;
    int beat_t[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic void emit(int n);
        logic [W*P-1:0] d;
        logic [P-1:0]   k;
        d = '0;
        k = '0;
        for (int i = 0; i < n; i++) begin
            d[i*W +: W] = pend.pop_front();
            k[i] = 1'b1;
        end
        exp_d.push_back(d);
        exp_k.push_back(k);
    endfunction

    task automatic push_byte(lane_t b);
        mem[wr_ptr] = b;
        wr_ptr++;
        pend.push_back(b);
        if (pend.size() == P) emit(P);
    endtask

    always @(posedge rclock) cyc <= cyc + 1;

    always @(negedge rclock) begin
        if (fifo_r_en && fifo_empty) empty_pops++;
    end

    // Monitor: every accepted beat must match the next expected one
    always @(negedge rclock) begin
        if (rreset && out_valid && out_ready) begin
            if (exp_d.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %h keep %h", out_data, out_keep);
            end else begin
                check("beat_data", 64'(out_data), 64'(exp_d.pop_front()));
                check("beat_keep", 64'(out_keep), 64'(exp_k.pop_front()));
            end
            beat_t.push_back(cyc);
        end
    end

    task automatic step;
        @(posedge rclock);
        #1;
    endtask

    task automatic drain;
        int n = 0;
        while (!(wr_ptr == rd_ptr && exp_d.size() == 0) && n < 400) begin
            step;
            n++;
        end
        check("drain_timeout", 64'(n >= 400), 64'(0));
        repeat (3) step;
    endtask

    task automatic do_flush(int n);
        flush = 1'b1;
        if (n > 0) emit(n);
        step;
        flush = 1'b0;
    endtask

    task automatic wait_valid(string name);
        int n = 0;
        while (!out_valid && n < 50) begin
            step;
            n++;
        end
        check(name, 64'(out_valid), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W*P-1:0] hold_d;
        logic           stable;
        int             pops;
        int             n;
        int             total;
        int             sent;
        int             k;

        // Reset with data waiting in the FIFO
        out_ready = 1'b1;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        repeat (2) step;
        check("reset_r_en", 64'(fifo_r_en), 64'(0));
        check("reset_valid", 64'(out_valid), 64'(0));
        check("reset_data", 64'(out_data), 64'(0));
        check("reset_keep", 64'(out_keep), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        rreset = 1'b1;
        #1;
        check("first_pop", 64'(fifo_r_en), 64'(1));
        drain;

        // Streaming: three full beats, 5-cycle spacing
        beat_t.delete();
        for (int i = 0; i < 12; i++) push_byte(lane_t'(8'h50 + i));
        drain;
        check("beat_count", 64'(beat_t.size()), 64'(3));
        if (beat_t.size() == 3) begin
            check("interval_1", 64'(beat_t[1] - beat_t[0]), 64'(P + 1));
            check("interval_2", 64'(beat_t[2] - beat_t[1]), 64'(P + 1));
        end

        // Backpressure: beat held, accumulator full, pops stop
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) push_byte(lane_t'(8'h60 + i));
        wait_valid("bp_valid");
        hold_d = out_data;
        stable = 1'b1;
        repeat (20) begin
            step;
            if (out_data !== hold_d || !out_valid) stable = 1'b0;
        end
        check("bp_stable", 64'(stable), 64'(1));
        check("bp_left_in_fifo", 64'(wr_ptr - rd_ptr), 64'(2));
        out_ready = 1'b1;
        drain;
        do_flush(2);
        drain;

        // Partial flush, then flush with nothing held
        push_byte(8'hA1);
        push_byte(8'hA2);
        push_byte(8'hA3);
        drain;
        do_flush(3);
        drain;
        do_flush(0);
        repeat (5) step;
        check("empty_flush_busy", 64'(busy), 64'(0));

        // Flush in the same cycle as a pop
        push_byte(8'hB1);
        push_byte(8'hB2);
        push_byte(8'hB3);
        step;
        flush = 1'b1;
        check("pop_with_flush", 64'(fifo_r_en), 64'(1));
        emit(2);
        step;
        flush = 1'b0;
        pops = 0;
        n = 0;
        while (!out_valid && n < 20) begin
            if (fifo_r_en) pops++;
            step;
            n++;
        end
        check("flush_no_pop", 64'(pops), 64'(0));
        check("flush_beat", 64'(out_valid), 64'(1));
        push_byte(8'hB4);
        push_byte(8'hB5);
        push_byte(8'hB6);
        drain;

        // Asynchronous reset mid-word
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_byte(lane_t'(8'hC0 + i));
        wait_valid("rst_valid");
        repeat (4) step;
        #2;
        fifo_clr = 1'b1;
        rreset = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'(0));
        check("arst_data", 64'(out_data), 64'(0));
        check("arst_keep", 64'(out_keep), 64'(0));
        check("arst_r_en", 64'(fifo_r_en), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        exp_d.delete();
        exp_k.delete();
        pend.delete();
        repeat (2) step;
        rreset = 1'b1;
        fifo_clr = 1'b0;
        out_ready = 1'b1;
        push_byte(8'hD0);
        push_byte(8'hD1);
        push_byte(8'hD2);
        push_byte(8'hD3);
        drain;

        // Random traffic with random backpressure
        total = P * $urandom_range(5, 10);
        sent = 0;
        while (sent < total) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                push_byte(lane_t'($urandom));
                sent++;
            end
            step;
        end
        out_ready = 1'b1;
        drain;
        k = $urandom_range(1, P - 1);
        for (int i = 0; i < k; i++) push_byte(lane_t'($urandom));
        drain;
        do_flush(k);
        drain;

        check("all_beats_seen", 64'(exp_d.size()), 64'(0));
        check("no_pop_when_empty", 64'(empty_pops), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
